// File: rtl/chunked_seq_adder_if.sv
// Request/result bundle for chunked_seq_adder: master drives operands and start,
// slave returns busy/done and the registered result.
interface chunked_seq_adder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/chunked_seq_adder.sv
// Sequential WIDTH-bit adder, one CHUNK-bit slice per clock with a carry register.
// Define CHUNKED_SEQ_ADDER_SATURATE_EN to clamp the sum on signed overflow.
module chunked_seq_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                clk,
   input  logic                rst,
   chunked_seq_adder_if.slave  bus
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
      add_slice = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [31:0]      base_s;
   logic [CHUNK-1:0] slice_a_s;
   logic [CHUNK-1:0] slice_b_s;
   logic [CHUNK:0]   slice_sum_s;
   logic             carry_msb_s;
   logic [WIDTH-1:0] result_s;

   // Slice datapath and next-state/next-output computation
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      part_d  = part_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = done_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      base_s      = 32'(idx_q) * 32'(CHUNK);
      slice_a_s   = CHUNK'(a_q >> base_s);
      slice_b_s   = CHUNK'(b_q >> base_s);
      slice_sum_s = add_slice(slice_a_s, slice_b_s, carry_q);
      // Carry into the slice MSB recovered from its sum bit; on the last slice this is the word's MSB
      carry_msb_s = slice_a_s[CHUNK-1] ^ slice_b_s[CHUNK-1] ^ slice_sum_s[CHUNK-1];
      result_s    = part_q | (WIDTH'(slice_sum_s[CHUNK-1:0]) << base_s);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            done_d = 1'b0;
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               part_d  = {WIDTH{1'b0}};
               idx_d   = {IDXW{1'b0}};
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            part_d  = result_s;
            carry_d = slice_sum_s[CHUNK];
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_sum_s[CHUNK];
               ovf_d   = carry_msb_s ^ slice_sum_s[CHUNK];
`ifdef CHUNKED_SEQ_ADDER_SATURATE_EN
               if ((carry_msb_s ^ slice_sum_s[CHUNK]) == 1'b1) begin
                  sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
               end else begin
                  sum_d = result_s;
               end
`else
               sum_d   = result_s;
`endif
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IDXW'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         part_q  <= {WIDTH{1'b0}};
         idx_q   <= {IDXW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         part_q  <= part_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed self-checking bench for chunked_seq_adder (WIDTH=32, CHUNK=8, N=4).
module tb_chunked_seq_adder;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   excl_bad;

   chunked_seq_adder_if #(.WIDTH(32)) bus ();

   chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one add, scramble the inputs after acceptance, wait (bounded) for done.
   task automatic do_add(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                         output logic [31:0] osum, output logic ocout, output logic oovf,
                         output int lat, output int busy_cnt);
      bus.start = 1'b1;
      bus.a     = ia;
      bus.b     = ib;
      bus.cin   = icin;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = ~ia;
      bus.b     = ib ^ 32'h5a5a_5a5a;
      bus.cin   = ~icin;
      lat       = -1;
      busy_cnt  = (bus.busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 12 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (bus.busy === 1'b1 && bus.done === 1'b1) excl_bad++;
         if (bus.done === 1'b1) lat = i;
         else if (bus.busy === 1'b1) busy_cnt++;
      end
      osum  = bus.sum;
      ocout = bus.cout;
      oovf  = bus.overflow;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.sum !== 32'h0) begin n_err++; $display("FAIL reset_sum got %h want 00000000", bus.sum); end
      n_cmp++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", bus.cout); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
      rst = 1'b0; bus.start = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_overflow();
      logic [31:0] s; logic c, o; int lat, bc;
      logic [31:0] exp1, exp2;
`ifdef CHUNKED_SEQ_ADDER_SATURATE_EN
      exp1 = 32'h7fff_ffff; exp2 = 32'h8000_0000;
`else
      exp1 = 32'h8000_0000; exp2 = 32'h7fff_ffff;
`endif
      do_add(32'h7fff_ffff, 32'h0000_0001, 1'b0, s, c, o, lat, bc);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ovf1_latency got %0d want 4", lat); end
      n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL ovf1_busy_cycles got %0d want 4", bc); end
      n_cmp++; if (s !== exp1) begin n_err++; $display("FAIL ovf1_sum got %h want %h", s, exp1); end
      n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL ovf1_cout got %b want 0", c); end
      n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL ovf1_ovf got %b want 1", o); end
      @(posedge clk); #1;
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
      n_cmp++; if (bus.sum !== exp1) begin n_err++; $display("FAIL ovf1_sum_hold got %h want %h", bus.sum, exp1); end
      do_add(32'hffff_ffff, 32'h8000_0000, 1'b0, s, c, o, lat, bc);
      n_cmp++; if (s !== exp2) begin n_err++; $display("FAIL ovf2_sum got %h want %h", s, exp2); end
      n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL ovf2_cout got %b want 1", c); end
      n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL ovf2_ovf got %b want 1", o); end
   endtask

   task automatic test_mixed_signs();
      logic [31:0] s; logic c, o; int lat, bc;
      do_add(32'h0000_0002, 32'hffff_fffb, 1'b0, s, c, o, lat, bc);
      n_cmp++; if ({s, c, o} !== {32'hffff_fffd, 1'b0, 1'b0}) begin n_err++; $display("FAIL mix1 got %h/%b/%b want fffffffd/0/0", s, c, o); end
      do_add(32'hffff_fffb, 32'hffff_fff4, 1'b0, s, c, o, lat, bc);
      n_cmp++; if ({s, c, o} !== {32'hffff_ffef, 1'b1, 1'b0}) begin n_err++; $display("FAIL mix2 got %h/%b/%b want ffffffef/1/0", s, c, o); end
      do_add(32'h0000_000c, 32'h0000_0019, 1'b0, s, c, o, lat, bc);
      n_cmp++; if ({s, c, o} !== {32'h0000_0025, 1'b0, 1'b0}) begin n_err++; $display("FAIL mix3 got %h/%b/%b want 00000025/0/0", s, c, o); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL mix3_latency got %0d want 4", lat); end
   endtask

   task automatic test_carry_chain();
      logic [31:0] s; logic c, o; int lat, bc;
      do_add(32'hffff_ffff, 32'h0000_0000, 1'b1, s, c, o, lat, bc);
      n_cmp++; if (s !== 32'h0) begin n_err++; $display("FAIL chain_sum got %h want 00000000", s); end
      n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL chain_cout got %b want 1", c); end
      n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL chain_ovf got %b want 0", o); end
   endtask

   task automatic test_back_to_back();
      int          de[3];
      logic [31:0] ds[3];
      int          nd;
      int          loc_excl;
      nd = 0; loc_excl = 0;
      bus.start = 1'b1; bus.a = 32'h2; bus.b = 32'h1; bus.cin = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         if (bus.busy === 1'b1 && bus.done === 1'b1) loc_excl++;
         if (bus.done === 1'b1) begin
            if (nd < 3) begin de[nd] = k; ds[nd] = bus.sum; end
            nd++;
         end
         bus.a = 32'h100 * k;
         bus.b = 32'(k);
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (nd !== 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", nd); end
      if (nd >= 3) begin
         n_cmp++; if (de[0] !== 5 || de[1] !== 10 || de[2] !== 15) begin n_err++; $display("FAIL b2b_done_edges got %0d,%0d,%0d want 5,10,15", de[0], de[1], de[2]); end
         n_cmp++; if (ds[0] !== 32'h3) begin n_err++; $display("FAIL b2b_sum1 got %h want 00000003", ds[0]); end
         n_cmp++; if (ds[1] !== 32'h505) begin n_err++; $display("FAIL b2b_sum2 got %h want 00000505", ds[1]); end
         n_cmp++; if (ds[2] !== 32'ha0a) begin n_err++; $display("FAIL b2b_sum3 got %h want 00000a0a", ds[2]); end
      end
      n_cmp++; if (loc_excl !== 0) begin n_err++; $display("FAIL b2b_busy_done_excl got %0d want 0", loc_excl); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] s; logic c, o; int lat, bc;
      int          saw_done;
      saw_done = 0;
      bus.start = 1'b1; bus.a = 32'h7; bus.b = 32'h8; bus.cin = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if (bus.done === 1'b1) saw_done++;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) saw_done++;
      end
      n_cmp++; if (saw_done !== 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", saw_done); end
      n_cmp++; if ({bus.sum, bus.cout, bus.overflow, bus.busy} !== {32'h0, 1'b0, 1'b0, 1'b0})
         begin n_err++; $display("FAIL abort_outputs got %h/%b/%b/%b want 00000000/0/0/0", bus.sum, bus.cout, bus.overflow, bus.busy); end
      do_add(32'h0, 32'h0000_000a, 1'b0, s, c, o, lat, bc);
      n_cmp++; if (s !== 32'h0000_000a) begin n_err++; $display("FAIL abort_next_sum got %h want 0000000a", s); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL abort_next_latency got %0d want 4", lat); end
   endtask

   task automatic test_outputs_hold();
      logic [31:0] s; logic c, o; int lat, bc;
      do_add(32'h7, 32'h8, 1'b0, s, c, o, lat, bc);
      n_cmp++; if (s !== 32'hf) begin n_err++; $display("FAIL hold_sum_initial got %h want 0000000f", s); end
      for (int i = 0; i < 10; i++) begin
         bus.start = 1'b0;
         bus.a     = 32'h1357_9bdf + 32'(i);
         bus.b     = 32'hfedc_ba98 - 32'(i);
         bus.cin   = i[0];
         @(posedge clk); #1;
         n_cmp++; if (bus.sum !== 32'hf || bus.done !== 1'b0)
            begin n_err++; $display("FAIL hold_cycle%0d got sum=%h done=%b want 0000000f/0", i, bus.sum, bus.done); end
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; excl_bad = 0;
      rst = 1'b1; bus.start = 1'b0; bus.a = 32'h0; bus.b = 32'h0; bus.cin = 1'b0;
      test_reset();
      test_overflow();
      test_mixed_signs();
      test_carry_chain();
      test_back_to_back();
      test_reset_mid();
      test_outputs_hold();
      n_cmp++; if (excl_bad !== 0) begin n_err++; $display("FAIL busy_done_exclusive got %0d overlaps want 0", excl_bad); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
